// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op encodings and FSM states.
package mem_stage_pkg;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic {
        RUN     = 1'b0,
        LD_WAIT = 1'b1
    } stage_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-stage to memory-stage bus, plus the registered result toward write-back.
// Handshake: an operation transfers on a rising edge where in_valid && in_ready;
// op/alu_ans/mem_addr/st_data are don't-care otherwise. ans_valid is a one-cycle
// pulse per result with no downstream back-pressure.
interface mem_access_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] alu_ans;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] mux_ans_dm;
    logic              ans_valid;
    logic              err;

    modport master (
        output in_valid, op, alu_ans, mem_addr, st_data,
        input  in_ready, mux_ans_dm, ans_valid, err
    );

    modport slave (
        input  in_valid, op, alu_ans, mem_addr, st_data,
        output in_ready, mux_ans_dm, ans_valid, err
    );
endinterface

// File: rtl/mem_access_stage_data_ram.sv
// Small data memory: synchronous write, synchronous registered read. Array is not reset;
// only the read register is.
module data_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU pass-through, load or store per accepted op,
// with a one-cycle load wait that stalls the execute stage.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_stage_if.slave   bus,
    output stage_state_e        state_dbg
);
    stage_state_e      state, state_n;
    logic              accept;
    logic              ram_we, ram_re;
    logic              res_load, ans_n, err_set;
    logic [DATA_W-1:0] res_n, rd_q, mux_q;
    logic              ans_q, err_q;

    assign bus.in_ready   = (state == RUN);
    assign accept         = bus.in_valid && (state == RUN);
    assign bus.mux_ans_dm = mux_q;
    assign bus.ans_valid  = ans_q;
    assign bus.err        = err_q;
    assign state_dbg      = state;

    always_comb begin
        state_n  = state;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        res_load = 1'b0;
        res_n    = rd_q;
        ans_n    = 1'b0;
        err_set  = 1'b0;
        if (state == LD_WAIT) begin
            // Read data registered last edge is now forwarded to write-back.
            res_load = 1'b1;
            res_n    = rd_q;
            ans_n    = 1'b1;
            state_n  = RUN;
        end else if (accept) begin
            case (bus.op)
                OP_ALU: begin
                    res_load = 1'b1;
                    res_n    = bus.alu_ans;
                    ans_n    = 1'b1;
                end
                OP_LD: begin
                    ram_re  = 1'b1;
                    state_n = LD_WAIT;
                end
                OP_ST: begin
                    ram_we = 1'b1;
                end
                default: begin
                    err_set = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_q <= '0;
            ans_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ans_q <= ans_n;
            if (res_load) begin
                mux_q <= res_n;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (bus.mem_addr),
        .wdata (bus.st_data),
        .rd_q  (rd_q)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random ops, checked by a
// scoreboard fed from a memory/result reference model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int W  = 8;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    stage_state_e state_dbg;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(W), .ADDR_W(AW)) bus ();

    mem_access_stage #(.DATA_W(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    logic [W-1:0] ref_mem [1 << AW];
    bit           written [1 << AW];
    logic         err_exp  = 1'b0;
    logic [W-1:0] last_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           d;
        if (!rst_n) begin
            last_val = '0;
        end else if (bus.ans_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ans_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("result_data", 32'(bus.mux_ans_dm), 32'(e));
                check("result_latency", 32'(cyc), 32'(d));
                last_val = e;
            end
        end else begin
            check("result_hold", 32'(bus.mux_ans_dm), 32'(last_val));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_fields();
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.alu_ans  = W'($urandom);
        bus.mem_addr = AW'($urandom);
        bus.st_data  = W'($urandom);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [AW-1:0] ad, input logic [W-1:0] d, output int waits);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.alu_ans  = a;
        bus.mem_addr = ad;
        bus.st_data  = d;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
        waits = n;
        case (o)
            OP_ALU: begin exp_q.push_back(a); due_q.push_back(cyc + 1); end
            OP_LD:  begin exp_q.push_back(ref_mem[ad]); due_q.push_back(cyc + 2); end
            OP_ST:  begin ref_mem[ad] = d; written[ad] = 1'b1; end
            default: err_exp = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        idle_fields();
        check("err_flag", 32'(bus.err), 32'(err_exp));
    endtask

    task automatic do_reset(input bit wait_edge);
        if (wait_edge) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        err_exp = 1'b0;
        #1;
        check("rst_mux_ans_dm", 32'(bus.mux_ans_dm), 32'd0);
        check("rst_ans_valid", 32'(bus.ans_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(RUN));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int r;
        logic [AW-1:0] ad;
        idle_fields();
        do_reset(1'b1);

        // ALU pass right after reset
        issue(OP_ALU, 8'h5A, '0, '0, w);
        check("alu_valid_now", 32'(bus.ans_valid), 32'd1);
        check("alu_value_now", 32'(bus.mux_ans_dm), 32'h5A);
        @(negedge clk);
        check("alu_valid_pulse", 32'(bus.ans_valid), 32'd0);

        // store then load of the same address on the next cycle
        issue(OP_ST, '0, 4'h7, 8'hC3, w);
        issue(OP_LD, '0, 4'h7, '0, w);
        check("ld_stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("ld_stall_state", 32'(state_dbg), 32'(LD_WAIT));
        @(negedge clk);
        check("ld_done_in_ready", 32'(bus.in_ready), 32'd1);

        // back-pressure: load, then two ALU ops held valid
        issue(OP_LD, '0, 4'h7, '0, w);
        issue(OP_ALU, 8'h11, '0, '0, w);
        check("bp_wait_cycles", 32'(w), 32'd1);
        issue(OP_ALU, 8'h22, '0, '0, w);
        check("bp_no_wait", 32'(w), 32'd0);
        repeat (3) @(negedge clk);

        // illegal op: sticky error, no result
        issue(OP_ILL, 8'hEE, 4'h3, 8'hEE, w);
        check("ill_no_valid", 32'(bus.ans_valid), 32'd0);
        issue(OP_ALU, 8'h33, '0, '0, w);
        issue(OP_ST, '0, 4'h3, 8'h44, w);
        repeat (2) @(negedge clk);
        check("ill_err_sticky", 32'(bus.err), 32'd1);
        do_reset(1'b1);
        check("err_cleared", 32'(bus.err), 32'd0);

        // reset during LD_WAIT abandons the load
        issue(OP_LD, '0, 4'h7, '0, w);
        check("midld_state", 32'(state_dbg), 32'(LD_WAIT));
        do_reset(1'b0);
        check("midld_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("midld_no_result", 32'(bus.mux_ans_dm), 32'd0);

        // address extremes
        issue(OP_ST, '0, 4'hF, 8'h99, w);
        issue(OP_ST, '0, 4'h0, 8'h01, w);
        issue(OP_LD, '0, 4'hF, '0, w);
        issue(OP_LD, '0, 4'h0, '0, w);
        repeat (3) @(negedge clk);

        // random traffic
        repeat (300) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r  = $urandom_range(0, 19);
            ad = AW'($urandom);
            if (r <= 7) begin
                issue(OP_ALU, W'($urandom), AW'($urandom), W'($urandom), w);
            end else if (r <= 12 || !written[ad]) begin
                issue(OP_ST, W'($urandom), ad, W'($urandom), w);
            end else if (r <= 18) begin
                issue(OP_LD, W'($urandom), ad, W'($urandom), w);
            end else begin
                issue(OP_ILL, W'($urandom), ad, W'($urandom), w);
            end
        end

        // drain outstanding results
        r = 0;
        while (exp_q.size() != 0 && r < 10) begin
            @(negedge clk);
            r++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
